// File: rtl/regbank_bus_arbiter_pkg.sv
// Shared types and constants for the two-master register-bank bus arbiter.
package regbank_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Wide enough for any practical DATA_W; users slice off the low bits.
  localparam int unsigned MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/regbank_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the master
// that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regbank_bus_arbiter.sv
// Arbitrates two masters onto a single register-bank port, with one
// outstanding transaction and a Done timeout that returns an error.
module regbank_bus_arbiter
  import regbank_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_rd,
  output logic              s_wr,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rd_done,
  input  logic              s_wr_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = ERR_RDATA[DATA_W-1:0];

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]        gnt;
  logic              done_match;

  // grant_q doubles as the last-grant memory (1 = m1) for the tie-breaker.
  rr_arb2 u_rr_arb2 (
    .req_i  ({m1_req, m0_req}),
    .last_i (grant_q),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    done_match = we_q ? s_wr_done : s_rd_done;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          grant_d = gnt[1];
          we_d    = gnt[1] ? m1_we    : m0_we;
          addr_d  = gnt[1] ? m1_addr  : m0_addr;
          wdata_d = gnt[1] ? m1_wdata : m0_wdata;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_match) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
          if (!we_q) begin
            if (grant_q) m1_rdata_d = s_rdata;
            else         m0_rdata_d = s_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Timeout reports all-ones regardless of direction.
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (grant_q) m1_rdata_d = ERR_DATA;
          else         m0_rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_rd     = (state_q == ST_ISSUE) && !we_q;
    s_wr     = (state_q == ST_ISSUE) && we_q;
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    m0_ack   = (state_q == ST_RESP) && !grant_q;
    m1_ack   = (state_q == ST_RESP) && grant_q;
    m0_err   = m0_ack && err_q;
    m1_err   = m1_ack && err_q;
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
  end

endmodule

// File: tb/tb_regbank_bus_arbiter.sv
// Directed self-checking bench for regbank_bus_arbiter with a small
// register-bank responder model driven from the stimulus thread.
module tb_regbank_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic        s_rd, s_wr, s_rd_done, s_wr_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] bankMem [0:255];

  int          ackAt;
  logic [1:0]  ackMask;
  logic        ackErr;
  logic [31:0] ackData;
  int          rdCount, wrCount;
  logic        overlap;
  int          lateAcks;

  regbank_bus_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rd      (s_rd),
    .s_wr      (s_wr),
    .s_rdata   (s_rdata),
    .s_rd_done (s_rd_done),
    .s_wr_done (s_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one transaction from the IDLE cycle (k=1) where the request is
  // visible; answers the strobe 'latency' cycles later (0 = never) and can
  // inject the wrong-kind Done one cycle after the strobe.
  task automatic applyStimulus(input int latency, input bit stray, input int limit);
    int k;
    int strobeK;
    logic strobeWe;
    logic [7:0] strobeAddr;
    k = 1; strobeK = 0; strobeWe = 1'b0; strobeAddr = '0;
    ackAt = -1; ackMask = '0; ackErr = 1'b0; ackData = '0;
    rdCount = 0; wrCount = 0; overlap = 1'b0;
    while (k < limit && ackAt < 0) begin
      @(negedge clk);
      k++;
      s_rd_done = 1'b0;
      s_wr_done = 1'b0;
      if (s_rd && s_wr) overlap = 1'b1;
      if (s_rd || s_wr) begin
        strobeK = k;
        strobeWe = s_wr;
        strobeAddr = s_addr;
        if (s_wr) begin
          wrCount++;
          bankMem[s_addr] = s_wdata;
        end else begin
          rdCount++;
        end
      end
      if (m0_ack || m1_ack) begin
        ackAt = k;
        ackMask = {m1_ack, m0_ack};
        ackErr = m1_ack ? m1_err : m0_err;
        ackData = m1_ack ? m1_rdata : m0_rdata;
      end else if (strobeK > 0) begin
        if (stray && k == strobeK + 1) begin
          if (strobeWe) s_rd_done = 1'b1;
          else          s_wr_done = 1'b1;
        end
        if (latency > 0 && k == strobeK + latency) begin
          if (strobeWe) begin
            s_wr_done = 1'b1;
          end else begin
            s_rd_done = 1'b1;
            s_rdata = bankMem[strobeAddr];
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_rd_done = 1'b0; s_wr_done = 1'b0;
    for (int i = 0; i < 256; i++) bankMem[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    checkOutput("rst_strobes", {s_rd, s_wr}, 2'b00);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    checkOutput("rst_s_addr", s_addr, 8'h00);
    checkOutput("rst_s_wdata", s_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // m0 write, bank answers two cycles after the strobe
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h00; m0_wdata = 32'h0000_1234;
    applyStimulus(2, 1'b0, 30);
    checkOutput("wr_ack_cycle", 64'(ackAt), 64'd5);
    checkOutput("wr_ack_mask", ackMask, 2'b01);
    checkOutput("wr_err", ackErr, 1'b0);
    checkOutput("wr_strobes", {32'(wrCount), 32'(rdCount)}, {32'd1, 32'd0});
    checkOutput("wr_bank_r0", bankMem[0], 32'h0000_1234);
    checkOutput("wr_rdata_kept", ackData, 32'h0);
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("wr_ack_one_cycle", m0_ack, 1'b0);

    // m1 read, wrong-kind Done injected before the real one
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h00;
    applyStimulus(2, 1'b1, 30);
    checkOutput("rd_ack_cycle", 64'(ackAt), 64'd5);
    checkOutput("rd_ack_mask", ackMask, 2'b10);
    checkOutput("rd_err", ackErr, 1'b0);
    checkOutput("rd_rdata", ackData, 32'h0000_1234);
    checkOutput("rd_strobes", {32'(wrCount), 32'(rdCount)}, {32'd1 - 32'd1, 32'd1});
    m1_req = 1'b0;
    @(negedge clk);
    checkOutput("rd_rdata_hold", m1_rdata, 32'h0000_1234);

    // Both masters requesting continuously from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h02; m0_wdata = 32'hAAAA_0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1, 1'b0, 30);
      checkOutput($sformatf("rr_grant%0d", t), ackMask, (t % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr_strobes%0d", t), {32'(rdCount + wrCount), 31'd0, overlap}, {32'd1, 32'd0});
      if (t % 2 == 1) checkOutput($sformatf("rr_rdata%0d", t), ackData, 32'hAAAA_0000);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout with Done tied low, then a late Done
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05;
    applyStimulus(0, 1'b0, 40);
    checkOutput("to_ack_cycle", 64'(ackAt), 64'd18);
    checkOutput("to_ack_mask", ackMask, 2'b10);
    checkOutput("to_err", ackErr, 1'b1);
    checkOutput("to_rdata", ackData, 32'hFFFF_FFFF);
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    s_rd_done = 1'b1; s_rdata = 32'h5555_5555;
    lateAcks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_rd_done = 1'b0;
      if (m0_ack || m1_ack) lateAcks++;
    end
    checkOutput("late_done_no_ack", 64'(lateAcks), 64'd0);
    checkOutput("late_done_rdata", m1_rdata, 32'hFFFF_FFFF);

    // Reset while waiting on the bank
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h03; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("abort_issue", {s_wr, s_addr, s_wdata}, {1'b1, 8'h03, 32'hDEAD_BEEF});
    @(negedge clk);
    rst_n = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_rst_bus", {s_rd, s_wr, s_addr, s_wdata}, {2'b00, 8'h00, 32'h0});
    checkOutput("abort_rst_out", {m0_ack, m1_ack, m0_err, m1_err, m1_rdata}, {4'b0000, 32'h0});
    rst_n = 1'b1; s_wr_done = 1'b1;
    @(negedge clk);
    s_wr_done = 1'b0;
    checkOutput("abort_stray_ack", {m0_ack, m1_ack}, 2'b00);
    @(negedge clk);
    checkOutput("abort_idle", {m0_ack, m1_ack, s_rd, s_wr}, 4'b0000);

    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h00;
    applyStimulus(1, 1'b0, 30);
    checkOutput("post_rst_cycle", 64'(ackAt), 64'd4);
    checkOutput("post_rst_mask", ackMask, 2'b10);
    checkOutput("post_rst_rdata", {ackErr, ackData}, {1'b0, 32'h0000_1234});
    m1_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
